mac_dot_seq: RTL
================

// Module: mac_dot_seq
// PURPOSE
//  Operand-side sequencer (initiator) for the floating-point mac unit.
//  Buffers a vector of (a, b) pairs plus a bias, then drives the mac's
//  stb/add_b_stb, in_mult/coeff/in_add ports, and chains mac_out back as in_add.
//  Returns one dot product  bias + sum(a[i]*b[i])  per vector.
//  Feeds one systolic-array PE; all values are IEEE-754 single precision.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width (IEEE-754 binary32)
//  DEPTH        8   max vector length held in the operand buffer
//  MAC_LATENCY  12  cycles with stb high before mac_out is valid (>=1)
// PORTS
//  clk            in   1    clock; all logic on rising edge
//  rst            in   1    synchronous, active-low reset
//  load_valid     in   1    operand beat valid
//  load_ready     out  1    beat accepted when load_valid & load_ready
//  load_a         in   DW   multiplicand a[i]
//  load_b         in   DW   coefficient b[i]
//  load_last      in   1    final beat of vector
//  bias           in   DW   initial accumulator; sampled with first beat
//  mac_stb        out  1    to mac stb
//  mac_add_b_stb  out  1    to mac add_b_stb
//  mac_in_mult    out  DW   to mac in_mult
//  mac_coeff      out  DW   to mac coeff
//  mac_in_add     out  DW   to mac in_add (running accumulator)
//  mac_out        in   DW   from mac mac_out
//  res_valid      out  1    result available
//  res_ready      in   1    result consumed when res_valid & res_ready
//  res_data       out  DW   dot-product result
//  busy           out  1    high in every state except IDLE
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE; every output 0; count, index, acc 0.
//    Applies from any state; an in-flight vector is dropped, no result emitted.
//  - FSM: IDLE -> LOAD -> ISSUE <-> WAIT -> RESULT -> IDLE.
//  - IDLE/LOAD: load_ready=1. Each accepted beat is written at buf[count];
//    count++. First beat (from IDLE) also loads acc<=bias and goes to LOAD.
//    Beat with load_last, or the beat making count==DEPTH, ends loading
//    (forced last) -> ISSUE, index=0. Length is never 0.
//  - ISSUE (1 cycle): strobes 0; mac_in_mult/mac_coeff <= buf[index],
//    mac_in_add <= acc. -> WAIT, wait counter cleared.
//  - WAIT: mac_stb=mac_add_b_stb=1, operands held stable, for exactly
//    MAC_LATENCY cycles. At edge ending last WAIT cycle: acc<=mac_out, index++;
//    -> ISSUE if index<count, else RESULT. Strobes drop in ISSUE, so mac
//    sees one low cycle between elements.
//  - RESULT: res_valid=1, res_data=acc, both stable until res_ready.
//    Handshake -> IDLE, count cleared. res_ready high on entry: 1-cycle RESULT.
//  - load_ready=0 in ISSUE/WAIT/RESULT; load_valid there is ignored.
//  - Latency: res_valid rises count*(MAC_LATENCY+1)+1 cycles after last-beat
//    acceptance edge.
//  - No FP arithmetic here; acc is an opaque DW-bit register.
// STRUCTURE
//  - Shared header mac_defs.vh: state encodings (IDLE,LOAD,ISSUE,WAIT,RESULT),
//    DATA_WIDTH default, FP constants FP_ZERO=32'h0, FP_ONE=32'h3F800000.
//  - Sub-module mac_operand_buf: DEPTH x (2*DW) register file, 1 write port,
//    1 async read port; counters widths $clog2(DEPTH+1) in top.
// TESTING (bench instantiates mac_dot_seq + real mac, MAC_LATENCY matched)
//  1 len1: a=b=bias=32'h40000000, load_last=1 -> res_data=32'h40C00000 (6.0)
//    exactly MAC_LATENCY+2 cycles after accept.
//  2 len3: a={1,2,3}, b={2,2,2}, bias=0 -> res_data=32'h41400000 (12.0);
//    mac_stb low exactly 1 cycle between elements, high MAC_LATENCY each.
//  3 overflow: DEPTH=8, 9 beats with no load_last -> 8 accepted, load_ready
//    low after 8th; result = 8-term sum; 9th beat accepted only back in IDLE.
//  4 backpressure: res_ready low 5 cycles -> res_valid/res_data stable;
//    raise -> IDLE next cycle, load_ready=1.
//  5 reset mid-WAIT: rst=0 one cycle -> all outputs 0, no res_valid;
//    new len1 vector afterwards gives correct result (acc from its own bias).
//  6 load_valid held high in ISSUE/WAIT -> load_ready=0, buffer unchanged.

Source files
------------

// File: rtl/mac_dot_seq_pkg.sv
// Shared types and constants for the mac operand sequencer.
// Holds the FSM encoding, default width, FP constants and a width helper.
package mac_dot_seq_pkg;

  localparam int          DW_DEF  = 32;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  // Address/counter width for n entries, never below one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_dot_seq_if.sv
// Load, result and mac-side signals of the sequencer bundled in one interface.
// slave = sequencer view, master = producer/consumer/mac view.
interface mac_dot_seq_if #(
  parameter int DW = 32
);
  logic          load_valid;
  logic          load_ready;
  logic [DW-1:0] load_a;
  logic [DW-1:0] load_b;
  logic          load_last;
  logic [DW-1:0] bias;

  logic          mac_stb;
  logic          mac_add_b_stb;
  logic [DW-1:0] mac_in_mult;
  logic [DW-1:0] mac_coeff;
  logic [DW-1:0] mac_in_add;
  logic [DW-1:0] mac_out;

  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          busy;

  modport slave (
    input  load_valid, load_a, load_b, load_last, bias, mac_out, res_ready,
    output load_ready, mac_stb, mac_add_b_stb, mac_in_mult, mac_coeff,
           mac_in_add, res_valid, res_data, busy
  );

  modport master (
    output load_valid, load_a, load_b, load_last, bias, mac_out, res_ready,
    input  load_ready, mac_stb, mac_add_b_stb, mac_in_mult, mac_coeff,
           mac_in_add, res_valid, res_data, busy
  );

endinterface

// File: rtl/mac_dot_seq_operand_buf.sv
// DEPTH x {a,b} operand register file: one write port, one async read port.
module mac_operand_buf #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [2*DW-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [2*DW-1:0] o_rdata
);

  logic [2*DW-1:0] r_mem [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge i_clk) begin
      if (!i_rst)                                r_mem[g] <= '0;
      else if (i_we && (i_waddr == AW'(g)))      r_mem[g] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mac_dot_seq.sv
// Operand-side sequencer for the FP mac: buffers one vector of (a,b) plus bias,
// feeds the mac one element at a time, chains mac_out back as in_add.
module mac_dot_seq
  import mac_dot_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = DW_DEF,
  parameter int DEPTH       = 8,
  parameter int MAC_LATENCY = 12
) (
  input logic          i_clk,
  input logic          i_rst,
  mac_dot_seq_if.slave io_bus
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = addr_w(DEPTH);
  localparam int WW = addr_w(MAC_LATENCY);

  state_e          r_state, w_nxt;
  logic [CW-1:0]   r_count, r_index;
  logic [WW-1:0]   r_wait;
  logic [DW-1:0]   r_acc, r_in_mult, r_coeff, r_in_add;
  logic            r_load_ready;

  logic            w_beat, w_last_beat, w_wait_done, w_more;
  logic            w_stb, w_res_valid, w_busy;
  logic [2*DW-1:0] w_rdata;

  assign w_beat      = io_bus.load_valid & r_load_ready;
  // A full buffer forces the beat to be treated as the last one.
  assign w_last_beat = w_beat & (io_bus.load_last | (r_count == CW'(DEPTH - 1)));
  assign w_wait_done = (r_wait == WW'(MAC_LATENCY - 1));
  assign w_more      = (r_index + CW'(1)) < r_count;

  mac_operand_buf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_beat),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata ({io_bus.load_a, io_bus.load_b}),
    .i_raddr (r_index[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_stb       = 1'b0;
    w_res_valid = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_beat) w_nxt = w_last_beat ? ST_ISSUE : ST_LOAD;
      end
      ST_LOAD:   if (w_last_beat) w_nxt = ST_ISSUE;
      ST_ISSUE:  w_nxt = ST_WAIT;
      ST_WAIT: begin
        w_stb = 1'b1;
        if (w_wait_done) w_nxt = w_more ? ST_ISSUE : ST_RESULT;
      end
      ST_RESULT: begin
        w_res_valid = 1'b1;
        if (io_bus.res_ready) w_nxt = ST_IDLE;
      end
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // load_ready is registered so it reads 0 in the cycle right after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_load_ready <= 1'b0;
      r_count      <= '0;
      r_index      <= '0;
      r_wait       <= '0;
      r_acc        <= '0;
      r_in_mult    <= '0;
      r_coeff      <= '0;
      r_in_add     <= '0;
    end else begin
      r_load_ready <= (w_nxt == ST_IDLE) || (w_nxt == ST_LOAD);
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_beat) begin
            r_count <= r_count + CW'(1);
            if (r_state == ST_IDLE) r_acc <= io_bus.bias;
            if (w_last_beat)        r_index <= '0;
          end
        end
        ST_ISSUE: begin
          r_in_mult <= w_rdata[2*DW-1:DW];
          r_coeff   <= w_rdata[DW-1:0];
          r_in_add  <= r_acc;
          r_wait    <= '0;
        end
        ST_WAIT: begin
          r_wait <= r_wait + WW'(1);
          if (w_wait_done) begin
            r_acc   <= io_bus.mac_out;
            r_index <= r_index + CW'(1);
          end
        end
        ST_RESULT: if (io_bus.res_ready) r_count <= '0;
        default: ;
      endcase
    end
  end

  assign io_bus.load_ready    = r_load_ready;
  assign io_bus.mac_stb       = w_stb;
  assign io_bus.mac_add_b_stb = w_stb;
  assign io_bus.mac_in_mult   = r_in_mult;
  assign io_bus.mac_coeff     = r_coeff;
  assign io_bus.mac_in_add    = r_in_add;
  assign io_bus.res_valid     = w_res_valid;
  assign io_bus.res_data      = r_acc;
  assign io_bus.busy          = w_busy;

endmodule
